// File: rtl/kernel_weight_writer.sv
// Write side of the kernel-weight RAM: takes a valid/ready stream of weight words after a
// start pulse and stores them kernel-major, then channel, then row-major taps.
module kernel_weight_writer #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int N_CHANNELS       = 3,
    parameter int N_KERNELS        = 3,
    parameter int KERNEL_SIZE      = 3,
    parameter int KERNEL_BASE_ADDR = 0
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          data_valid_i,
    output logic                          data_ready_o,
    output logic [ADDR_WIDTH-1:0]         wraddress_o,
    output logic [DATA_WIDTH-1:0]         wrdata_o,
    output logic                          wren_o,
    output logic [$clog2(N_KERNELS):0]    kernel_index_o,
    output logic [$clog2(N_CHANNELS):0]   channel_index_o,
    output logic                          kernel_done_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
    localparam int TAP_W = $clog2(TAPS) + 1;
    localparam int KW    = $clog2(N_KERNELS) + 1;
    localparam int CW    = $clog2(N_CHANNELS) + 1;

    localparam logic [TAP_W-1:0]      TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [CW-1:0]         CH_LAST  = CW'(N_CHANNELS - 1);
    localparam logic [KW-1:0]         K_LAST   = KW'(N_KERNELS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(KERNEL_BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                state, next_state;
    logic [TAP_W-1:0]      tap;
    logic [ADDR_WIDTH-1:0] word_count;
    logic                  accept;
    logic                  start_load;
    logic                  last_tap;
    logic                  last_channel;
    logic                  last_word;

    assign accept       = data_valid_i & data_ready_o;
    assign start_load   = start_i & (state != S_LOAD);
    assign last_tap     = (tap == TAP_LAST);
    assign last_channel = last_tap & (channel_index_o == CH_LAST);
    assign last_word    = last_channel & (kernel_index_o == K_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start_i) next_state = S_LOAD;
            S_LOAD:  if (accept && last_word) next_state = S_DONE;
            S_DONE:  if (start_i) next_state = S_LOAD;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        data_ready_o = 1'b0;
        busy_o       = 1'b0;
        if (state == S_LOAD) begin
            data_ready_o = 1'b1;
            busy_o       = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wren_o          <= 1'b0;
            wraddress_o     <= '0;
            wrdata_o        <= '0;
            kernel_done_o   <= 1'b0;
            done_o          <= 1'b0;
            tap             <= '0;
            channel_index_o <= '0;
            kernel_index_o  <= '0;
            word_count      <= '0;
        end else begin
            wren_o        <= accept;
            kernel_done_o <= accept & last_channel;
            // done follows the first DONE cycle so it rises after the final write lands
            done_o        <= (state == S_DONE) && (next_state == S_DONE);

            if (start_load) begin
                tap             <= '0;
                channel_index_o <= '0;
                kernel_index_o  <= '0;
                word_count      <= '0;
            end else if (accept) begin
                wraddress_o <= BASE + word_count;
                wrdata_o    <= data_i;
                word_count  <= word_count + ADDR_WIDTH'(1);
                if (last_tap) begin
                    tap <= '0;
                    if (channel_index_o == CH_LAST) begin
                        channel_index_o <= '0;
                        kernel_index_o  <= kernel_index_o + KW'(1);
                    end else begin
                        channel_index_o <= channel_index_o + CW'(1);
                    end
                end else begin
                    tap <= tap + TAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_weight_writer.sv
// Bench for kernel_weight_writer: scoreboard-checked weight loads on the default geometry
// plus a minimal 1x1x1 instance.
module tb_kernel_weight_writer;

    localparam int TOTAL = 81;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [15:0] wraddr;
    logic [31:0] wrdata;
    logic        wren;
    logic [2:0]  kidx;
    logic [2:0]  cidx;
    logic        kdone;
    logic        busy;
    logic        done;

    logic        m_start;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_wraddr;
    logic [31:0] m_wrdata;
    logic        m_wren;
    logic [0:0]  m_kidx;
    logic [0:0]  m_cidx;
    logic        m_kdone;
    logic        m_busy;
    logic        m_done;

    always #5 clk = ~clk;

    kernel_weight_writer #(
        .KERNEL_BASE_ADDR(16'h0100)
    ) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .data_i(data),
        .data_valid_i(valid), .data_ready_o(ready), .wraddress_o(wraddr),
        .wrdata_o(wrdata), .wren_o(wren), .kernel_index_o(kidx),
        .channel_index_o(cidx), .kernel_done_o(kdone), .busy_o(busy), .done_o(done)
    );

    kernel_weight_writer #(
        .N_CHANNELS(1), .N_KERNELS(1), .KERNEL_SIZE(1), .KERNEL_BASE_ADDR(16'h0040)
    ) dut_min (
        .clock_i(clk), .reset_i(rst), .start_i(m_start), .data_i(m_data),
        .data_valid_i(m_valid), .data_ready_o(m_ready), .wraddress_o(m_wraddr),
        .wrdata_o(m_wrdata), .wren_o(m_wren), .kernel_index_o(m_kidx),
        .channel_index_o(m_cidx), .kernel_done_o(m_kdone), .busy_o(m_busy), .done_o(m_done)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        kd;
    } wr_t;

    wr_t sb[$];
    wr_t e;
    int  total    = 0;
    int  bad      = 0;
    int  word_idx = 0;
    int  wr_count = 0;
    int  kd_count = 0;
    int  saved;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start    = 1'b0;
        word_idx = 0;
    endtask

    // Drives n words; expectations are queued at the negedge before the accepting posedge.
    task automatic load_words(input int n, input bit stall, input int mid_start_at);
        int sent   = 0;
        int cycles = 0;
        int hold   = 0;
        bit v      = 1'b1;
        bit pulsed = 1'b0;
        wr_t w;
        while (sent < n && cycles < 3000) begin
            if (stall) begin
                if (hold == 0) begin
                    v    = !v;
                    hold = $urandom_range(1, 3);
                end
                hold--;
            end else begin
                v = 1'b1;
            end
            if (ready) begin
                check("kernel_index", kidx, word_idx / 27);
                check("channel_index", cidx, (word_idx / 9) % 3);
            end
            start = 1'b0;
            if (mid_start_at >= 0 && word_idx == mid_start_at && !pulsed) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
            valid = v;
            data  = 32'h0001_0000 * word_idx;
            if (v && ready) begin
                w.addr = 16'h0100 + 16'(word_idx);
                w.data = 32'h0001_0000 * word_idx;
                w.kd   = (word_idx % 27) == 26;
                sb.push_back(w);
                word_idx++;
                sent++;
            end
            tick();
            cycles++;
        end
        valid = 1'b0;
        start = 1'b0;
        check("load_budget", sent, n);
    endtask

    always @(negedge clk) begin
        if (wren) begin
            wr_count++;
            if (kdone) kd_count++;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", wraddr, e.addr);
                check("wr_data", wrdata, e.data);
                check("kernel_done", kdone, e.kd);
            end
        end else if (kdone) begin
            check("kdone_without_write", 1, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        valid   = 1'b0;
        data    = '0;
        m_start = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        repeat (3) tick();

        check("rst_wren", wren, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_kdone", kdone, 0);
        check("rst_kidx", kidx, 0);
        check("rst_cidx", cidx, 0);
        check("rst_addr", wraddr, 0);
        check("rst_data", wrdata, 0);
        rst = 1'b0;
        tick();
        check("idle_ready", ready, 0);

        // back-to-back load
        pulse_start();
        check("load_busy", busy, 1);
        wr_count = 0;
        kd_count = 0;
        load_words(TOTAL, 1'b0, -1);
        check("last_write_ready", ready, 0);
        check("last_write_busy", busy, 0);
        check("last_write_done", done, 0);
        check("done_kidx", kidx, 3);
        check("done_cidx", cidx, 0);
        tick();
        check("done_rises", done, 1);
        check("done_no_wren", wren, 0);
        check("b2b_writes", wr_count, TOTAL);
        check("b2b_kdones", kd_count, 3);
        check("b2b_sb_empty", sb.size(), 0);

        // valid while in DONE must not write
        saved = wr_count;
        valid = 1'b1;
        repeat (5) tick();
        valid = 1'b0;
        check("done_no_writes", wr_count, saved);
        check("done_holds", done, 1);

        // reload from DONE with stalls and an ignored mid-load start
        pulse_start();
        check("reload_done_clr", done, 0);
        check("reload_busy", busy, 1);
        wr_count = 0;
        kd_count = 0;
        load_words(TOTAL, 1'b1, 11);
        tick();
        tick();
        check("stall_writes", wr_count, TOTAL);
        check("stall_kdones", kd_count, 3);
        check("stall_done", done, 1);
        check("stall_sb_empty", sb.size(), 0);

        // reset one cycle after word 40 is accepted
        pulse_start();
        load_words(41, 1'b0, -1);
        rst = 1'b1;
        tick();
        check("midrst_wren", wren, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 0);
        check("midrst_kidx", kidx, 0);
        check("midrst_sb_empty", sb.size(), 0);
        rst = 1'b0;
        tick();
        wr_count = 0;
        pulse_start();
        load_words(TOTAL, 1'b0, -1);
        tick();
        tick();
        check("after_rst_writes", wr_count, TOTAL);
        check("after_rst_done", done, 1);
        check("after_rst_sb_empty", sb.size(), 0);

        // minimal 1x1x1 geometry
        check("min_idle_done", m_done, 0);
        m_start = 1'b1;
        tick();
        m_start = 1'b0;
        check("min_ready", m_ready, 1);
        m_valid = 1'b1;
        m_data  = 32'hDEAD_BEEF;
        tick();
        m_valid = 1'b0;
        check("min_wren", m_wren, 1);
        check("min_addr", m_wraddr, 16'h0040);
        check("min_data", m_wrdata, 32'hDEAD_BEEF);
        check("min_kdone", m_kdone, 1);
        check("min_done_early", m_done, 0);
        check("min_ready_drop", m_ready, 0);
        tick();
        check("min_done", m_done, 1);
        check("min_wren_off", m_wren, 0);
        check("min_kdone_off", m_kdone, 0);
        check("min_kidx", m_kidx, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
